// File: rtl/ins_fetch_if.sv
// ---------------------------------------------------------------------------
// ins_fetch_if
// Bus bundle for the instruction fetch stage.
//   DDR read address channel : ddr_addr, ddr_size, ddr_addr_valid / ddr_addr_ready
//   DDR read data channel    : ddr_data, ddr_valid / ddr_ready
//   Instruction channel      : ins, ins_valid / ins_ready
// master : the fetch stage (issues DDR bursts, produces instructions)
// slave  : the environment (DDR controller plus instruction consumer)
// ---------------------------------------------------------------------------
interface ins_fetch_if #(
    parameter int DDR_W      = 512,
    parameter int INST_W     = 128,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 8
) ();
    logic [DDR_ADDR_W-1:0] ddr_addr;
    logic [BURST_W-1:0]    ddr_size;
    logic                  ddr_addr_valid;
    logic                  ddr_addr_ready;
    logic [DDR_W-1:0]      ddr_data;
    logic                  ddr_valid;
    logic                  ddr_ready;
    logic [INST_W-1:0]     ins;
    logic                  ins_valid;
    logic                  ins_ready;

    modport master (
        output ddr_addr, ddr_size, ddr_addr_valid,
        input  ddr_addr_ready,
        input  ddr_data, ddr_valid,
        output ddr_ready,
        output ins, ins_valid,
        input  ins_ready
    );

    modport slave (
        input  ddr_addr, ddr_size, ddr_addr_valid,
        output ddr_addr_ready,
        output ddr_data, ddr_valid,
        input  ddr_ready,
        input  ins, ins_valid,
        output ins_ready
    );
endinterface

// File: rtl/ins_fetch.sv
// ---------------------------------------------------------------------------
// ins_fetch
// Instruction fetch stage: reads a contiguous program from DDR in bursts,
// unpacks each DDR word into IPW instructions (lane 0 first), buffers them in
// a first-word-fall-through FIFO and presents them on a valid/ready port.
// A done pulse follows once the FIFO has drained and top_working is low.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active low
//   start        one-cycle start pulse, ignored unless idle
//   base_addr    byte address of instruction 0 (DDR_W/8 aligned)
//   ins_cnt      instruction count, 0 allowed
//   busy         program in flight
//   done         one-cycle completion pulse
//   top_working  consumer still executing
//   bus          ins_fetch_if.master: DDR address/data channels + ins channel
//
// FIFO_DEPTH is expected to be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ins_fetch #(
    parameter int DDR_W      = 512,
    parameter int INST_W     = 128,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 8,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DDR_ADDR_W-1:0] base_addr,
    input  logic [15:0]           ins_cnt,
    output logic                  busy,
    output logic                  done,
    input  logic                  top_working,
    ins_fetch_if.master           bus
);
    localparam int IPW        = DDR_W / INST_W;
    localparam int BEAT_BYTES = DDR_W / 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int LANE_W     = $clog2(IPW + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state;
    logic [15:0]           words_left;
    logic [15:0]           ins_left_wr;
    logic [DDR_ADDR_W-1:0] cur_addr;
    logic [BURST_W-1:0]    beats;
    logic [DDR_ADDR_W-1:0] addr_q;
    logic [BURST_W-1:0]    size_q;
    logic                  addr_valid_q;
    logic                  ddr_ready_q;

    logic [INST_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    // ------------------------------------------------------------------
    // Burst sizing and FIFO space
    // ------------------------------------------------------------------
    logic [15:0]        words_total;
    logic [BURST_W-1:0] start_len;
    logic [BURST_W-1:0] req_len;
    logic [CNT_W-1:0]   need;
    logic               space_ok;

    assign words_total = (ins_cnt / 16'(IPW)) + {15'd0, |(ins_cnt % 16'(IPW))};
    assign start_len   = (words_total >= 16'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                          : BURST_W'(words_total);
    assign req_len     = (words_left >= 16'(MAX_BURST))  ? BURST_W'(MAX_BURST)
                                                          : BURST_W'(words_left);
    // A burst is only requested once the whole burst fits, so the data
    // channel can run with ddr_ready held high and never overflow the FIFO.
    assign need        = CNT_W'(req_len) * CNT_W'(IPW);
    assign space_ok    = (CNT_W'(FIFO_DEPTH) - count) >= need;

    // ------------------------------------------------------------------
    // FIFO push/pop control
    // ------------------------------------------------------------------
    logic              beat_fire;
    logic [LANE_W-1:0] n_wr;
    logic [LANE_W-1:0] n_push;
    logic              pop;

    assign beat_fire = bus.ddr_valid && ddr_ready_q;
    // Surplus lanes of the final word are dropped by limiting the lane count.
    assign n_wr      = (ins_left_wr >= 16'(IPW)) ? LANE_W'(IPW) : LANE_W'(ins_left_wr);
    assign n_push    = beat_fire ? n_wr : '0;
    assign pop       = (count != '0) && bus.ins_ready;

    // NOTE: the storage array has no reset; only the pointers and the count
    // define which entries are valid, so flushing means clearing those.
    always_ff @(posedge clk) begin
        for (int k = 0; k < IPW; k++) begin
            if (beat_fire && (LANE_W'(k) < n_wr))
                mem[wr_ptr + PTR_W'(k)] <= bus.ddr_data[k*INST_W +: INST_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(n_push) - CNT_W'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            words_left   <= '0;
            ins_left_wr  <= '0;
            cur_addr     <= '0;
            beats        <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            addr_valid_q <= 1'b0;
            ddr_ready_q  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        words_left  <= words_total;
                        ins_left_wr <= ins_cnt;
                        cur_addr    <= base_addr;
                        if (ins_cnt != 16'd0) begin
                            // The FIFO is always empty in IDLE, so the first
                            // request can go out without a space check.
                            addr_q       <= base_addr;
                            size_q       <= start_len;
                            addr_valid_q <= 1'b1;
                            state        <= S_REQ;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end

                S_REQ: begin
                    if (addr_valid_q) begin
                        if (bus.ddr_addr_ready) begin
                            addr_valid_q <= 1'b0;
                            ddr_ready_q  <= 1'b1;
                            beats        <= size_q;
                            cur_addr     <= cur_addr + DDR_ADDR_W'(size_q) * DDR_ADDR_W'(BEAT_BYTES);
                            words_left   <= words_left - 16'(size_q);
                            state        <= S_DATA;
                        end
                    end else if (space_ok) begin
                        addr_q       <= cur_addr;
                        size_q       <= req_len;
                        addr_valid_q <= 1'b1;
                    end
                end

                S_DATA: begin
                    if (beat_fire) begin
                        ins_left_wr <= ins_left_wr - 16'(n_wr);
                        beats       <= beats - BURST_W'(1);
                        if (beats == BURST_W'(1)) begin
                            ddr_ready_q <= 1'b0;
                            state       <= (words_left != 16'd0) ? S_REQ : S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if ((count == '0) && !top_working) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ddr_addr       = addr_q;
    assign bus.ddr_size       = size_q;
    assign bus.ddr_addr_valid = addr_valid_q;
    assign bus.ddr_ready      = ddr_ready_q;
    assign bus.ins_valid      = (count != '0);
    // Head entry is gated so ins reads as zero while the FIFO is empty.
    assign bus.ins            = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ins_fetch.sv
// ---------------------------------------------------------------------------
// tb_ins_fetch
// Self-checking bench for ins_fetch. A DDR responder returns words whose
// lanes encode (program tag, instruction index) derived from the requested
// address; expected bursts and instructions are queued when each program is
// started and popped as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_ins_fetch;
    localparam int DDR_W      = 512;
    localparam int INST_W     = 128;
    localparam int DDR_ADDR_W = 32;
    localparam int BURST_W    = 8;
    localparam int MAX_BURST  = 16;
    localparam int FIFO_DEPTH = 64;
    localparam int IPW        = DDR_W / INST_W;
    localparam int BEAT_BYTES = DDR_W / 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  size;
    } burst_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] ins_cnt;
    logic        busy;
    logic        done;
    logic        top_working;

    ins_fetch_if #(.DDR_W(DDR_W), .INST_W(INST_W), .DDR_ADDR_W(DDR_ADDR_W), .BURST_W(BURST_W)) bus ();

    ins_fetch #(
        .DDR_W(DDR_W), .INST_W(INST_W), .DDR_ADDR_W(DDR_ADDR_W),
        .BURST_W(BURST_W), .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .ins_cnt(ins_cnt),
        .busy(busy),
        .done(done),
        .top_working(top_working),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    burst_t       exp_bursts[$];
    burst_t       act_bursts[$];
    logic [127:0] exp_ins[$];

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] prog_tag = 32'h0;
    logic [31:0] prog_base = 32'h0;
    int lanes_left = 0;
    int queued = 0;
    int beats_in_prog = 0;
    int bursts_seen = 0;
    int done_cnt = 0;
    int beat_idx = 0;
    int addr_wait = 0;
    int addr_delay = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit rand_data = 0;
    bit junk = 0;

    bit           prev_addr_pend = 0;
    logic [31:0]  prev_addr;
    logic [7:0]   prev_size;
    bit           prev_ins_pend = 0;
    logic [127:0] prev_ins;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_ins(input logic [31:0] tag, input logic [31:0] idx);
        return {tag, idx, ~idx, idx ^ 32'hA5A5_5A5A};
    endfunction

    function automatic logic [511:0] mk_word(input logic [31:0] tag, input logic [31:0] base,
                                             input logic [31:0] addr);
        logic [511:0] w;
        logic [31:0]  first;
        first = ((addr - base) >> 6) << 2;
        for (int k = 0; k < IPW; k++)
            w[k*INST_W +: INST_W] = mk_ins(tag, first + 32'(k));
        return w;
    endfunction

    // Queue the expected bursts and instructions of a new program.
    task automatic setup_prog(input logic [31:0] base, input int cnt);
        int          words;
        int          sz;
        logic [31:0] a;
        prog_tag      = prog_tag + 32'h1;
        prog_base     = base;
        lanes_left    = cnt;
        beats_in_prog = 0;
        words = (cnt + IPW - 1) / IPW;
        a = base;
        while (words > 0) begin
            sz = (words > MAX_BURST) ? MAX_BURST : words;
            exp_bursts.push_back({a, 8'(sz)});
            a = a + 32'(sz * BEAT_BYTES);
            words -= sz;
        end
        for (int i = 0; i < cnt; i++)
            exp_ins.push_back(mk_ins(prog_tag, 32'(i)));
    endtask

    // Call right after a negedge.
    task automatic pulse_start(input logic [31:0] base, input int cnt);
        #1;
        base_addr = base;
        ins_cnt   = 16'(cnt);
        start     = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < budget);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_ins_left"}, exp_ins.size(), 0);
        check({tag, "_bursts_left"}, exp_bursts.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // DDR responder, consumer and monitors (all on the falling edge)
    // ------------------------------------------------------------------
    initial begin
        int n;
        bus.ddr_addr_ready = 1'b0;
        bus.ddr_valid      = 1'b0;
        bus.ddr_data       = '0;
        bus.ins_ready      = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bus.ddr_addr_ready = 1'b0;
                bus.ddr_valid      = 1'b0;
                act_bursts.delete();
                beat_idx       = 0;
                addr_wait      = 0;
                prev_addr_pend = 0;
                prev_ins_pend  = 0;
                queued         = 0;
                continue;
            end
            if (done) done_cnt++;

            // Address channel
            if (prev_addr_pend) begin
                check("addr_hold_valid", bus.ddr_addr_valid, 1'b1);
                check("addr_hold_addr", bus.ddr_addr, prev_addr);
                check("addr_hold_size", bus.ddr_size, prev_size);
            end
            if (bus.ddr_addr_valid) addr_wait++;
            bus.ddr_addr_ready = bus.ddr_addr_valid && (addr_wait > addr_delay);
            if (bus.ddr_addr_valid && bus.ddr_addr_ready) begin
                bursts_seen++;
                addr_wait      = 0;
                prev_addr_pend = 0;
                if (exp_bursts.size() == 0) begin
                    check("burst_count", exp_bursts.size(), 1);
                end else begin
                    burst_t b;
                    b = exp_bursts.pop_front();
                    check("burst_addr", bus.ddr_addr, b.addr);
                    check("burst_size", bus.ddr_size, b.size);
                end
                act_bursts.push_back({bus.ddr_addr, bus.ddr_size});
            end else begin
                prev_addr_pend = bus.ddr_addr_valid;
                prev_addr      = bus.ddr_addr;
                prev_size      = bus.ddr_size;
            end

            // Data channel
            if (act_bursts.size() != 0) begin
                bus.ddr_data  = mk_word(prog_tag, prog_base, act_bursts[0].addr + 32'(beat_idx * BEAT_BYTES));
                bus.ddr_valid = rand_data ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.ddr_valid && bus.ddr_ready) begin
                    beats_in_prog++;
                    n = (lanes_left < IPW) ? lanes_left : IPW;
                    lanes_left -= n;
                    queued     += n;
                    check("fifo_occupancy", queued <= FIFO_DEPTH, 1'b1);
                    beat_idx++;
                    if (beat_idx == int'(act_bursts[0].size)) begin
                        void'(act_bursts.pop_front());
                        beat_idx = 0;
                    end
                end
            end else begin
                bus.ddr_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.ddr_data  = {16{$urandom()}};
                if (bus.ddr_valid && bus.ddr_ready)
                    check("ddr_ready_without_burst", bus.ddr_ready, 1'b0);
            end

            // Instruction channel
            if (prev_ins_pend) begin
                check("ins_hold_valid", bus.ins_valid, 1'b1);
                check("ins_hold_data", bus.ins, prev_ins);
            end
            case (ready_mode)
                0:       bus.ins_ready = 1'b1;
                1:       bus.ins_ready = 1'($urandom_range(0, 1));
                default: bus.ins_ready = 1'b0;
            endcase
            if (bus.ins_valid && bus.ins_ready) begin
                prev_ins_pend = 0;
                queued--;
                if (exp_ins.size() == 0) check("ins_count", exp_ins.size(), 1);
                else                     check("ins_data", bus.ins, exp_ins.pop_front());
            end else begin
                prev_ins_pend = bus.ins_valid;
                prev_ins      = bus.ins;
            end
        end
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int b0;
        int d0;
        int c;
        rst = 1'b0;
        start = 1'b0;
        top_working = 1'b0;
        base_addr = '0;
        ins_cnt = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr_valid", bus.ddr_addr_valid, 1'b0);
        check("rst_addr", bus.ddr_addr, 32'h0);
        check("rst_size", bus.ddr_size, 8'h0);
        check("rst_ddr_ready", bus.ddr_ready, 1'b0);
        check("rst_ins_valid", bus.ins_valid, 1'b0);
        check("rst_ins", bus.ins, 128'h0);
        #1 rst = 1'b1;
        @(negedge clk);

        // Single short program with top_working holding done back
        top_working = 1'b1;
        b0 = bursts_seen;
        setup_prog(32'h1000, 6);
        pulse_start(32'h1000, 6);
        check("t1_addr_valid_after_start", bus.ddr_addr_valid, 1'b1);
        c = 0;
        while (exp_ins.size() != 0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("t1_all_ins", exp_ins.size(), 0);
        repeat (3) @(negedge clk);
        check("t1_done_held", done, 1'b0);
        check("t1_busy_held", busy, 1'b1);
        #1 top_working = 1'b0;
        @(negedge clk);
        check("t1_done", done, 1'b1);
        @(negedge clk);
        check("t1_done_pulse", done, 1'b0);
        check("t1_busy_clear", busy, 1'b0);
        check("t1_bursts", bursts_seen - b0, 1);

        // Multi-burst program, with a start pulse while busy
        b0 = bursts_seen;
        setup_prog(32'h1000, 130);
        pulse_start(32'h1000, 130);
        repeat (20) @(negedge clk);
        pulse_start(32'h9000, 5);
        wait_done("t2", 3000);
        check("t2_bursts", bursts_seen - b0, 3);
        @(negedge clk);

        // Backpressure: consumer stalled for 200 cycles
        #1 ready_mode = 2;
        setup_prog(32'h8000, 256);
        pulse_start(32'h8000, 256);
        repeat (200) @(negedge clk);
        check("bp_beats", beats_in_prog, 16);
        check("bp_addr_stall", bus.ddr_addr_valid, 1'b0);
        check("bp_ins_valid", bus.ins_valid, 1'b1);
        check("bp_queued", queued, FIFO_DEPTH);
        #1 ready_mode = 0;
        wait_done("t3", 3000);
        @(negedge clk);

        // Zero count with top_working held high
        #1 top_working = 1'b1;
        b0 = bursts_seen;
        d0 = done_cnt;
        setup_prog(32'h5000, 0);
        pulse_start(32'h5000, 0);
        repeat (10) @(negedge clk);
        check("t4_no_done", done_cnt, d0);
        check("t4_busy", busy, 1'b1);
        #1 top_working = 1'b0;
        @(negedge clk);
        check("t4_done", done, 1'b1);
        check("t4_no_burst", bursts_seen, b0);
        @(negedge clk);

        // Stalled handshakes, random data valid, address wrap
        #1;
        addr_delay = 5;
        rand_data  = 1;
        junk       = 1;
        ready_mode = 1;
        b0 = bursts_seen;
        setup_prog(32'hFFFF_FC00, 70);
        pulse_start(32'hFFFF_FC00, 70);
        wait_done("t5", 5000);
        check("t5_bursts", bursts_seen - b0, 2);
        #1;
        addr_delay = 0;
        rand_data  = 0;
        junk       = 0;
        ready_mode = 0;
        @(negedge clk);

        // Reset mid-DATA, then restart
        setup_prog(32'h3000, 40);
        pulse_start(32'h3000, 40);
        c = 0;
        while (!(beats_in_prog >= 2 && bus.ddr_ready) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("t6_in_data", bus.ddr_ready, 1'b1);
        d0 = done_cnt;
        #2 rst = 1'b0;
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_done", done, 1'b0);
        check("t6_rst_addr_valid", bus.ddr_addr_valid, 1'b0);
        check("t6_rst_addr", bus.ddr_addr, 32'h0);
        check("t6_rst_size", bus.ddr_size, 8'h0);
        check("t6_rst_ddr_ready", bus.ddr_ready, 1'b0);
        check("t6_rst_ins_valid", bus.ins_valid, 1'b0);
        check("t6_rst_ins", bus.ins, 128'h0);
        repeat (3) @(negedge clk);
        exp_ins.delete();
        exp_bursts.delete();
        check("t6_no_abort_done", done_cnt, d0);
        #1 rst = 1'b1;
        @(negedge clk);
        setup_prog(32'h4000, 4);
        pulse_start(32'h4000, 4);
        wait_done("t6", 500);
        @(negedge clk);
        check("t6_one_done", done_cnt, d0 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch stage directly upstream of the CNN training top.
- Reads a contiguous instruction program from DDR using bursts.
- Unpacks each DDR word into INST_W-bit instructions and buffers them in a FIFO.
- Presents instructions on the top's valid/ready instruction port.
- Signals completion once every instruction has been accepted and the top's `working` has dropped.

## Interface
- DDR_W, 512, DDR data width; must be a multiple of INST_W
- INST_W, 128, instruction width; IPW = DDR_W/INST_W = 4 instructions per word
- DDR_ADDR_W, 32, byte address width
- BURST_W, 8, burst size field width
- MAX_BURST, 16, maximum beats per burst
- FIFO_DEPTH, 64, instruction FIFO entries; must be ≥ MAX_BURST*IPW
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; ignored while busy
- base_addr  in  DDR_ADDR_W  byte address of instruction 0; aligned to DDR_W/8
- ins_cnt  in  16  number of instructions; 0 is legal
- busy  out  1  program in flight
- done  out  1  one-cycle pulse at program completion
- ddr_addr  out  DDR_ADDR_W  burst start byte address
- ddr_size  out  BURST_W  burst beat count, 1..MAX_BURST
- ddr_addr_valid / ddr_addr_ready  out / in  1  address handshake
- ddr_data  in  DDR_W  read data beat
- ddr_valid / ddr_ready  in / out  1  data handshake
- ins  out  INST_W  instruction to the top
- ins_valid / ins_ready  out / in  1  instruction handshake
- top_working  in  1  the top's `working` output

## Operation
- Quantities latched on start:
  - words = ceil(ins_cnt/IPW)
  - words_left = words
  - ins_left = ins_cnt
  - cur_addr = base_addr
- FSM states: IDLE, REQ, DATA, DRAIN, DONE.
  - **IDLE**: on start with ins_cnt>0, go to REQ with busy=1. On start with ins_cnt=0, go to DRAIN.
  - **REQ**: wait until FIFO free entries ≥ IPW*min(words_left, MAX_BURST).
    - Then drive ddr_addr_valid with ddr_addr=cur_addr and ddr_size=min(words_left, MAX_BURST).
    - Hold all three stable until ddr_addr_ready.
    - On the handshake:
      - beats = ddr_size
      - cur_addr += ddr_size*DDR_W/8, with DDR_ADDR_W wrap
      - words_left -= ddr_size
      - go to DATA
  - **DATA**: ddr_ready=1 (space was reserved in REQ).
    - Each beat writes lanes 0..IPW-1 into the FIFO; lane k = ddr_data[k*INST_W +: INST_W], lane 0 first.
    - Lanes are written only while ins_left_wr>0; each written lane decrements ins_left_wr. Surplus lanes of the final word are discarded.
    - After the last beat: go to REQ if words_left>0, otherwise go to DRAIN.
  - **DRAIN**: ddr_ready=0. Wait for FIFO empty and top_working=0, then go to DONE.
  - **DONE**: done=1 for one cycle, busy=0, return to IDLE.
- Only one burst is outstanding at a time.
- FIFO write port accepts up to IPW entries per cycle; read port delivers 1 entry per cycle.
- Output side:
  - ins_valid = FIFO not empty.
  - ins = FIFO head.
  - Pop on ins_valid && ins_ready.
- Any ddr_valid seen in IDLE, REQ, DRAIN or DONE is not accepted, because ddr_ready=0.

## Timing
- Reset values:
  - all outputs 0, busy=0, done=0, FIFO empty, FSM in IDLE
  - ddr_addr, ddr_size, ins = 0
- Reset asserted mid-program aborts immediately: the FIFO is flushed and no done pulse is produced.
- start → ddr_addr_valid: 1 cycle, when FIFO space is available.
- ddr beat accepted at cycle t → lane 0 visible on ins/ins_valid at t+1 (registered FIFO).
- FIFO is first-word-fall-through. A pop and a push in the same cycle are both honoured.
- ins, ins_valid and ddr_addr_valid are held stable until their handshake completes.
- done fires the cycle after DRAIN sees FIFO empty && !top_working. Minimum latency is 1 cycle after the last ins handshake.
- start received while busy is dropped. It produces no effect and no error.

## Test plan
- **Single short program**:
  - Stimulus: base_addr=0x1000, ins_cnt=6, ins_ready=1, ddr ready immediately.
  - Required: one burst with addr 0x1000, size 2.
  - Required: 6 instructions out in lane order; lanes 2–3 of word 1 dropped.
  - Required: done 1 cycle after top_working falls.
- **Multi-burst program**:
  - Stimulus: ins_cnt=130.
  - Required: bursts of 16, 16, 1 words at 0x1000, 0x1400, 0x1800.
  - Required: exactly 130 instructions out, in order.
- **Backpressure**:
  - Stimulus: ins_ready held 0 for 200 cycles, ins_cnt=256.
  - Required: FIFO never overflows; ddr_addr_valid stalls after 64 queued instructions; ins held stable throughout.
  - Required: on release, all 256 instructions are delivered in order.
- **Zero count and working hold**:
  - Stimulus: ins_cnt=0 with top_working=1 for 10 cycles.
  - Required: no DDR request; done fires in the cycle after top_working drops.
- **Stalled handshakes**:
  - Stimulus: ddr_addr_ready delayed 5 cycles; ddr_valid toggled randomly.
  - Required: addr and size stable while valid is high; data ordering is preserved.
- **Reset and restart**:
  - Stimulus: rst asserted low mid-DATA, then a new start with ins_cnt=4.
  - Required: all outputs return to 0 asynchronously; no done pulse for the aborted program.
  - Required: the new program completes cleanly with 4 instructions and one done pulse.
